// File: rtl/common.sv
// Shared bus types for the core-side fetch/data buses and the cached memory bus.
package common;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    // Encoded as beats minus one, AXI style.
    typedef enum logic [3:0] {
        MLEN1  = 4'd0,
        MLEN2  = 4'd1,
        MLEN4  = 4'd3,
        MLEN8  = 4'd7,
        MLEN16 = 4'd15
    } mlen_t;

    typedef logic [1:0] axi_burst_t;
    localparam axi_burst_t AXI_BURST_FIXED = 2'b00;
    localparam axi_burst_t AXI_BURST_INCR  = 2'b01;
    localparam axi_burst_t AXI_BURST_WRAP  = 2'b10;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        msize_t      size;
        logic [31:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        mlen_t       len;
        axi_burst_t  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

endpackage

// File: rtl/mem_req_arbiter.sv
// Serialises single-beat fetch and data transactions onto the cached bus and
// steers each completion back to the bus that issued it.
module mem_req_arbiter
    import common::*;
#(
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  ibus_req_t  ireq,
    output ibus_resp_t iresp,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output cbus_req_t  creq,
    input  cbus_resp_t cresp
);

    typedef enum logic [1:0] {
        IDLE,
        I_BUSY,
        D_BUSY
    } state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

    state_t    state_q, state_d;
    cbus_req_t req_q, req_d;
    owner_t    last_grant_q, last_grant_d;
    logic      done;
    logic      pick_d;

    always_comb begin
        // NOTE: every variable gets a default first, so no path can leave one unassigned and infer a latch.
        state_d      = state_q;
        req_d        = req_q;
        last_grant_d = last_grant_q;
        done         = (state_q != IDLE) && cresp.ready && cresp.last;

        // On a tie the round-robin mode favours whichever bus did not finish last.
        if (DATA_FIRST) begin
            pick_d = dreq.valid;
        end else begin
            pick_d = dreq.valid && (!ireq.valid || last_grant_q == OWN_I);
        end

        case (state_q)
            IDLE: begin
                if (pick_d) begin
                    state_d = D_BUSY;
                    req_d   = '{valid: 1'b1, is_write: |dreq.strobe, size: dreq.size,
                                addr: dreq.addr, strobe: dreq.strobe, data: dreq.data,
                                len: MLEN1, burst: AXI_BURST_FIXED};
                end else if (ireq.valid) begin
                    state_d = I_BUSY;
                    req_d   = '{valid: 1'b1, is_write: 1'b0, size: MSIZE4,
                                addr: ireq.addr, strobe: 8'h00, data: 64'h0,
                                len: MLEN1, burst: AXI_BURST_FIXED};
                end
            end
            I_BUSY: begin
                if (done) begin
                    state_d      = IDLE;
                    last_grant_d = OWN_I;
                end
            end
            D_BUSY: begin
                if (done) begin
                    state_d      = IDLE;
                    last_grant_d = OWN_D;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Responses are combinational so the pulse lands in the memory's completion cycle.
    always_comb begin
        creq  = (state_q != IDLE) ? req_q : '0;
        iresp = '0;
        dresp = '0;
        if (done && state_q == I_BUSY) begin
            iresp.addr_ok = 1'b1;
            iresp.data_ok = 1'b1;
            iresp.data    = req_q.addr[2] ? cresp.data[63:32] : cresp.data[31:0];
        end
        if (done && state_q == D_BUSY) begin
            dresp.addr_ok = 1'b1;
            dresp.data_ok = 1'b1;
            dresp.data    = cresp.data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            // NOTE: req_q is reset too, because creq must read back all-zero out of reset.
            req_q        <= '0;
            last_grant_q <= OWN_I;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Merges the core's instruction bus (`ireq`/`iresp`) and data bus (`dreq`/`dresp`) onto the single cached-bus port (`creq`/`cresp`) that leads to memory. It sits directly downstream of `core`, between the core's bus outputs and the memory/interconnect side. It serialises one single-beat transaction at a time and returns each response to the originating bus as a one-cycle `addr_ok`/`data_ok` pulse.

## Interface
- `DATA_FIRST`, default 1: 1 = fixed data-bus priority; 0 = round-robin on simultaneous requests.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high.
- `ireq` in `ibus_req_t`: fetch request; fields `valid`, `addr`.
- `iresp` out `ibus_resp_t`: fields `addr_ok`, `data_ok`, `data[31:0]`.
- `dreq` in `dbus_req_t`: data request; fields `valid`, `addr`, `size`, `strobe[7:0]`, `data[63:0]`.
- `dresp` out `dbus_resp_t`: fields `addr_ok`, `data_ok`, `data[63:0]`.
- `creq` out `cbus_req_t`: memory request; fields `valid`, `is_write`, `size`, `addr`, `strobe`, `data`, `len`, `burst`.
- `cresp` in `cbus_resp_t`: fields `ready`, `last`, `data[63:0]`.

## Operation
- FSM states are IDLE, I_BUSY and D_BUSY. Reset state is IDLE.
- **IDLE.** No request is driven.
  - If only `dreq.valid` is high: latch `dreq` into `req_q` and go to D_BUSY.
  - If only `ireq.valid` is high: latch a fetch and go to I_BUSY.
  - If both are high and `DATA_FIRST=1`: D wins.
  - If both are high and `DATA_FIRST=0`: the bus not granted last wins. The `last_grant` register resets to I, so D wins the first tie.
- **Latched fetch fields.** `addr`=`ireq.addr`, `size`=MSIZE4, `strobe`=0, `data`=0, `is_write`=0.
- **Latched data fields.** Copied from `dreq`, with `is_write` = |`dreq.strobe`.
- **creq in BUSY states.**
  - `creq.valid`=1 and all fields come from `req_q`.
  - `len`=MLEN1 and `burst`=AXI_BURST_FIXED.
  - `creq` is stable for the whole transaction.
- **creq in IDLE.** `creq.valid`=0 and the remaining fields are 0.
- **Completion.** Completion is the first cycle in a BUSY state where `cresp.ready && cresp.last`. In that cycle:
  - The owning bus gets `addr_ok`=`data_ok`=1 combinationally.
  - D_BUSY: `dresp.data`=`cresp.data`, unmodified.
  - I_BUSY: `iresp.data` = `req_q.addr[2]` ? `cresp.data[63:32]` : `cresp.data[31:0]`.
  - Next state is IDLE and `last_grant` is updated.
- **Non-completion BUSY cycles.** `cresp.ready` without `last` is ignored, since len is always 1.
- **Upstream rules.** Upstream must hold `valid` and payload until `data_ok`. If upstream drops `valid` mid-transaction, the latched transaction still completes and the response is still pulsed.
- **Non-owner bus.** Its `addr_ok`/`data_ok` stay 0 and its `data` is 0.

## Timing
- **Output reset values.** `creq`=0 (all fields), `iresp`=0, `dresp`=0, state IDLE, `last_grant`=I.
- **Request to memory.** A request seen in IDLE at cycle N gives `creq.valid` at cycle N+1.
- **Response.** The response pulse is in the same cycle as `cresp.ready&&last`, so minimum round trip is N+1.
- **Back-to-back.** A request still valid after completion re-arbitrates in the following IDLE cycle. There is exactly one dead IDLE cycle between transactions.
- **Reset mid-transaction.** The async reset drops `creq.valid` immediately and the FSM returns to IDLE. The outstanding transaction is abandoned and no response is issued.
- **Request at completion.** A request arriving in the completion cycle is not granted until the next IDLE cycle.

## Structure
- **Common package.** `cbus_req_t`/`cbus_resp_t`, `msize_t` (MSIZE1..8), `mlen_t` (MLEN1..), and the burst constants belong in the shared `common` package next to the ibus/dbus types.
- **Local types.** The FSM state enum and grant owner type are local to the module.
- **Sub-modules.** None. The FSM, the `req_q` register and response steering fit one module of about 150 lines.

## Test plan
- **Fetch only.** `ireq`{1, 0x8000_0004}, memory ready+last after 3 cycles with data 0x1111_2222_3333_4444 -> `creq` has size MSIZE4 and is_write=0 from cycle 1; `iresp.data_ok` for 1 cycle with data 0x1111_2222.
- **Store.** `dreq`{1, 0x8000_1000, MSIZE8, strobe 0xFF, 0xDEAD_BEEF_0000_0001} -> `creq.is_write`=1 with identical fields; single `dresp.addr_ok`/`data_ok` pulse; `iresp` stays 0.
- **Simultaneous requests, `DATA_FIRST=0`.** Both valid at cycle 0 -> D served first, then I; with both still pending, the next tie goes to D.
- **Simultaneous requests, `DATA_FIRST=1`.** Both valid continuously -> D served every transaction and I starved, which is the intended behaviour.
- **Mid-transaction reset.** Assert `reset` in D_BUSY -> `creq.valid` drops in the same cycle; no `dresp` pulse; after release a new `ireq` is served normally.
- **Held request.** `cresp.ready`=1 but `last`=0 for 2 cycles, then `last`=1 -> no response until `last`; `creq` held stable throughout.
